pipe_control_unit: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_decode.sv | 79 +++++++
 rtl/pipe_control_unit.sv | 169 ++++++++++++++++
 tb/tb_pipe_control_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle for the ID-stage decode and hazard unit.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LB    = 6'd32;
    localparam logic [5:0] OP_LH    = 6'd33;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_LBU   = 6'd36;
    localparam logic [5:0] OP_LHU   = 6'd37;
    localparam logic [5:0] OP_LWU   = 6'd39;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_IMM = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        RD_RT = 2'd0,
        RD_RD = 2'd1,
        RD_RA = 2'd2
    } regdst_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC  = 2'd2
    } memtoreg_t;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_WU = 3'd1;
    localparam logic [2:0] LD_B  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_H  = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    localparam logic [1:0] ST_W  = 2'd0;
    localparam logic [1:0] ST_B  = 2'd1;
    localparam logic [1:0] ST_H  = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        regdst_t    reg_dst;
        memtoreg_t  memto_reg;
        aluop_t     alu_op;
        logic       alu_src;
        logic       branch;
        logic       flag_branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] load_div;
        logic [1:0] store_div;
    } ctrl_bundle_t;

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && (fn >= FN_MULT) && (fn <= FN_DIVU);
    endfunction

    function automatic logic is_mfhilo(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn == FN_MFHI) || (fn == FN_MFLO));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct decoder producing the control bundle and the EX function code.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is registered.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
)(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output ctrl_bundle_t        ctrl,
    output logic [FUNCT_W-1:0]  fn,
    output logic                rt_src
);

    logic [5:0] op;
    assign op = 6'(opcode);

    always_comb begin
        ctrl   = '0;
        fn     = FUNCT_W'(opcode);
        rt_src = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = RD_RD;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
                fn             = funct;
                rt_src         = 1'b1;
            end
            OP_LW, OP_LWU, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.memto_reg = M2R_MEM;
                ctrl.reg_write = 1'b1;
                case (op)
                    OP_LWU:  ctrl.load_div = LD_WU;
                    OP_LB:   ctrl.load_div = LD_B;
                    OP_LBU:  ctrl.load_div = LD_BU;
                    OP_LH:   ctrl.load_div = LD_H;
                    OP_LHU:  ctrl.load_div = LD_HU;
                    default: ctrl.load_div = LD_W;
                endcase
            end
            OP_SW, OP_SB, OP_SH: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                rt_src         = 1'b1;
                case (op)
                    OP_SB:   ctrl.store_div = ST_B;
                    OP_SH:   ctrl.store_div = ST_H;
                    default: ctrl.store_div = ST_W;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch      = 1'b1;
                ctrl.flag_branch = (op == OP_BEQ);
                ctrl.alu_op      = ALUOP_BR;
                rt_src           = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_dst   = RD_RA;
                ctrl.memto_reg = M2R_PC;
                ctrl.reg_write = 1'b1;
            end
            default: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_IMM;
            end
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage decode with registered ID/EX control, load-use/flush bubbles; PIPE_CTRL_MULDIV_EN adds a MULT/DIV busy tracker.
// Latency: ex* outputs follow ID inputs by one clock; PC/IF-ID enables and IF/ID flush are combinational.
// Backpressure: hazards hold PC and IF/ID for one cycle (or until MULT/DIV retires) and inject a bubble; flush wins over stall.
module pipe_control_unit #(
    parameter int REG_ADDR_W    = 5,
    parameter int OPCODE_W      = 6,
    parameter int FUNCT_W       = 6,
    parameter int MULDIV_CYCLES = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   inOpcode,
    input  logic [FUNCT_W-1:0]    inFunction,
    input  logic [REG_ADDR_W-1:0] inRs,
    input  logic [REG_ADDR_W-1:0] inRt,
    input  logic [REG_ADDR_W-1:0] inRd,
    input  logic                  inFlush,
    output logic [1:0]            exRegDst,
    output logic [1:0]            exMemtoReg,
    output logic [1:0]            exALUOp,
    output logic                  exALUSrc,
    output logic                  exBranch,
    output logic                  exFlagBranch,
    output logic                  exJump,
    output logic                  exMemRead,
    output logic                  exMemWrite,
    output logic                  exRegWrite,
    output logic [2:0]            exLoadDiv,
    output logic [1:0]            exStoreDiv,
    output logic [FUNCT_W-1:0]    exFunction,
    output logic [REG_ADDR_W-1:0] exDestReg,
    output logic                  outPCWrite,
    output logic                  outIFIDWrite,
    output logic                  outIFIDFlush,
    output logic                  outBusy
);

    import pipe_ctrl_pkg::*;

    ctrl_bundle_t          id_ctrl;
    ctrl_bundle_t          ex_q;
    logic [FUNCT_W-1:0]    id_fn;
    logic [FUNCT_W-1:0]    ex_fn;
    logic [REG_ADDR_W-1:0] id_dest;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  id_rt_src;
    logic                  load_use;
    logic                  md_stall;
    logic                  stall;
    logic                  bubble;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_decode (
        .opcode   (inOpcode),
        .funct    (inFunction),
        .ctrl     (id_ctrl),
        .fn       (id_fn),
        .rt_src   (id_rt_src)
    );

    // A non-writing instruction carries dest 0 so it can never look like a hazard producer.
    always_comb begin
        id_dest = '0;
        if (id_ctrl.reg_write) begin
            case (id_ctrl.reg_dst)
                RD_RT:   id_dest = inRt;
                RD_RD:   id_dest = inRd;
                default: id_dest = REG_ADDR_W'(31);
            endcase
        end
    end

    // rt only counts as a source for R-type, store and branch; for loads/immediates it is the destination.
    assign load_use = ex_q.mem_read && (ex_dest != '0) &&
                      ((ex_dest == inRs) || ((ex_dest == inRt) && id_rt_src));

    assign stall        = (load_use || md_stall) && !inFlush;
    assign bubble       = stall || inFlush;
    assign outPCWrite   = !stall;
    assign outIFIDWrite = !stall;
    assign outIFIDFlush = inFlush;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ex_q    <= '0;
            ex_fn   <= '0;
            ex_dest <= '0;
        end else begin
            ex_q    <= id_ctrl;
            ex_fn   <= id_fn;
            ex_dest <= id_dest;
        end
    end

    assign exRegDst     = ex_q.reg_dst;
    assign exMemtoReg   = ex_q.memto_reg;
    assign exALUOp      = ex_q.alu_op;
    assign exALUSrc     = ex_q.alu_src;
    assign exBranch     = ex_q.branch;
    assign exFlagBranch = ex_q.flag_branch;
    assign exJump       = ex_q.jump;
    assign exMemRead    = ex_q.mem_read;
    assign exMemWrite   = ex_q.mem_write;
    assign exRegWrite   = ex_q.reg_write;
    assign exLoadDiv    = ex_q.load_div;
    assign exStoreDiv   = ex_q.store_div;
    assign exFunction   = ex_fn;
    assign exDestReg    = ex_dest;

`ifdef PIPE_CTRL_MULDIV_EN
    localparam int MD_CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

    md_state_t           md_state;
    md_state_t           md_state_nxt;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_nxt;
    logic                md_busy;
    logic                id_muldiv;
    logic                id_mfhilo;

    assign id_muldiv = is_muldiv(6'(inOpcode), 6'(inFunction));
    assign id_mfhilo = is_mfhilo(6'(inOpcode), 6'(inFunction));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    // Only a MULDIV op that actually lands in ID/EX starts the unit; flush leaves a running op alone.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (id_muldiv && !bubble) begin
                    md_state_nxt = MD_BUSY;
                    md_cnt_nxt   = MD_LOAD;
                end
            end
            default: begin
                if (md_cnt == '0) begin
                    md_state_nxt = MD_IDLE;
                end else begin
                    md_cnt_nxt = md_cnt - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        md_busy  = (md_state == MD_BUSY);
        md_stall = md_busy && (id_muldiv || id_mfhilo);
    end

    assign outBusy = md_busy;
`else
    assign md_stall = 1'b0;
    assign outBusy  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed, table-driven bench for pipe_control_unit: decode table plus hazard/flush/busy sequences.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] inOpcode;
    logic [5:0] inFunction;
    logic [4:0] inRs, inRt, inRd;
    logic       inFlush;
    logic [1:0] exRegDst, exMemtoReg, exALUOp;
    logic       exALUSrc, exBranch, exFlagBranch, exJump, exMemRead, exMemWrite, exRegWrite;
    logic [2:0] exLoadDiv;
    logic [1:0] exStoreDiv;
    logic [5:0] exFunction;
    logic [4:0] exDestReg;
    logic       outPCWrite, outIFIDWrite, outIFIDFlush, outBusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_control_unit #(
        .REG_ADDR_W    (5),
        .OPCODE_W      (6),
        .FUNCT_W       (6),
        .MULDIV_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inOpcode     (inOpcode),
        .inFunction   (inFunction),
        .inRs         (inRs),
        .inRt         (inRt),
        .inRd         (inRd),
        .inFlush      (inFlush),
        .exRegDst     (exRegDst),
        .exMemtoReg   (exMemtoReg),
        .exALUOp      (exALUOp),
        .exALUSrc     (exALUSrc),
        .exBranch     (exBranch),
        .exFlagBranch (exFlagBranch),
        .exJump       (exJump),
        .exMemRead    (exMemRead),
        .exMemWrite   (exMemWrite),
        .exRegWrite   (exRegWrite),
        .exLoadDiv    (exLoadDiv),
        .exStoreDiv   (exStoreDiv),
        .exFunction   (exFunction),
        .exDestReg    (exDestReg),
        .outPCWrite   (outPCWrite),
        .outIFIDWrite (outIFIDWrite),
        .outIFIDFlush (outIFIDFlush),
        .outBusy      (outBusy)
    );

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] memto_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       flag_branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] load_div;
        logic [1:0] store_div;
        logic [5:0] fn;
        logic [4:0] dest;
    } exo_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       flush;
        exo_t       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic exo_t sample();
        exo_t s;
        s = '{exRegDst, exMemtoReg, exALUOp, exALUSrc, exBranch, exFlagBranch, exJump,
              exMemRead, exMemWrite, exRegWrite, exLoadDiv, exStoreDiv, exFunction, exDestReg};
        return s;
    endfunction

    function automatic exo_t mk(input logic [1:0] rdst, input logic [1:0] m2r, input logic [1:0] aop,
                                input logic asrc, input logic br, input logic fb, input logic j,
                                input logic mr, input logic mw, input logic rw,
                                input logic [2:0] ld, input logic [1:0] st,
                                input logic [5:0] fn, input logic [4:0] dest);
        exo_t e;
        e = '{rdst, m2r, aop, asrc, br, fb, j, mr, mw, rw, ld, st, fn, dest};
        return e;
    endfunction

    task automatic add(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic flush, input exo_t exp);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.flush = flush; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic flush);
        inOpcode = op; inFunction = fn; inRs = rs; inRt = rt; inRd = rd; inFlush = flush;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Harmless filler: R-type writing r0, never a load, so it clears any pending hazard.
    task automatic clear();
        set_in(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
    endtask

    initial begin
        // rs=1, rt=2, rd=3 for every table entry.
        add("add",   6'd0,  6'h20, 1'b0, mk(1,0,2,0,0,0,0,0,0,1,0,0,6'h20,5'd3));
        add("slt",   6'd0,  6'h2A, 1'b0, mk(1,0,2,0,0,0,0,0,0,1,0,0,6'h2A,5'd3));
        add("lw",    6'd35, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,0,0,6'd35,5'd2));
        add("lwu",   6'd39, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,1,0,6'd39,5'd2));
        add("lb",    6'd32, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,2,0,6'd32,5'd2));
        add("lbu",   6'd36, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,3,0,6'd36,5'd2));
        add("lh",    6'd33, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,4,0,6'd33,5'd2));
        add("lhu",   6'd37, 6'h00, 1'b0, mk(0,1,0,1,0,0,0,1,0,1,5,0,6'd37,5'd2));
        add("sw",    6'd43, 6'h00, 1'b0, mk(0,0,0,1,0,0,0,0,1,0,0,0,6'd43,5'd0));
        add("sb",    6'd40, 6'h00, 1'b0, mk(0,0,0,1,0,0,0,0,1,0,0,1,6'd40,5'd0));
        add("sh",    6'd41, 6'h00, 1'b0, mk(0,0,0,1,0,0,0,0,1,0,0,2,6'd41,5'd0));
        add("beq",   6'd4,  6'h00, 1'b0, mk(0,0,1,0,1,1,0,0,0,0,0,0,6'd4,5'd0));
        add("bne",   6'd5,  6'h00, 1'b0, mk(0,0,1,0,1,0,0,0,0,0,0,0,6'd5,5'd0));
        add("j",     6'd2,  6'h00, 1'b0, mk(0,0,0,0,0,0,1,0,0,0,0,0,6'd2,5'd0));
        add("jal",   6'd3,  6'h00, 1'b0, mk(2,2,0,0,0,0,1,0,0,1,0,0,6'd3,5'd31));
        add("addi",  6'd8,  6'h00, 1'b0, mk(0,0,3,1,0,0,0,0,0,1,0,0,6'd8,5'd2));
        add("ori",   6'd13, 6'h00, 1'b0, mk(0,0,3,1,0,0,0,0,0,1,0,0,6'd13,5'd2));
        add("lui",   6'd15, 6'h00, 1'b0, mk(0,0,3,1,0,0,0,0,0,1,0,0,6'd15,5'd2));
        add("flush_add", 6'd0, 6'h20, 1'b1, '0);

        // Reset with a load sitting in ID
        rst_n = 1'b0;
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        check("reset_ex", 32'(sample()), 32'd0);
        check("reset_pcwrite", 32'(outPCWrite), 32'd1);
        check("reset_ifidwrite", 32'(outIFIDWrite), 32'd1);
        check("reset_ifidflush", 32'(outIFIDFlush), 32'd0);
        check("reset_busy", 32'(outBusy), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            clear();
            set_in(vecs[i].op, vecs[i].fn, 5'd1, 5'd2, 5'd3, vecs[i].flush);
            #1;
            check({vecs[i].name, "_ifidflush"}, 32'(outIFIDFlush), 32'(vecs[i].flush));
            step();
            check(vecs[i].name, 32'(sample()), 32'(vecs[i].exp));
        end

        // LW r8 then ADD rs=8: one stall cycle, bubble, then ADD
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        check("lu_lw_memread", 32'(exMemRead), 32'd1);
        check("lu_lw_dest", 32'(exDestReg), 32'd8);
        set_in(6'd0, 6'h20, 5'd8, 5'd0, 5'd10, 1'b0);
        #1;
        check("lu_pcwrite_stall", 32'(outPCWrite), 32'd0);
        check("lu_ifidwrite_stall", 32'(outIFIDWrite), 32'd0);
        step();
        check("lu_bubble", 32'(sample()), 32'd0);
        check("lu_pcwrite_release", 32'(outPCWrite), 32'd1);
        step();
        check("lu_add_dest", 32'(exDestReg), 32'd10);
        check("lu_add_regdst", 32'(exRegDst), 32'd1);

        // LW r8 then ADDI rt=8 rs=9: rt is a destination, no stall
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        set_in(6'd8, 6'd0, 5'd9, 5'd8, 5'd0, 1'b0);
        #1;
        check("addi_no_stall", 32'(outPCWrite), 32'd1);
        step();
        check("addi_dest", 32'(exDestReg), 32'd8);
        check("addi_aluop", 32'(exALUOp), 32'd3);

        // LW r8 then SW rt=8: store reads rt, stall
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        set_in(6'd43, 6'd0, 5'd9, 5'd8, 5'd0, 1'b0);
        #1;
        check("sw_rt_stall", 32'(outPCWrite), 32'd0);

        // LW r8 then BEQ rt=8: branch reads rt, stall
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        set_in(6'd4, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0);
        #1;
        check("beq_rt_stall", 32'(outIFIDWrite), 32'd0);

        // LW r0 then ADD rs=0: r0 never creates a hazard
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        check("lw_r0_memread", 32'(exMemRead), 32'd1);
        set_in(6'd0, 6'h20, 5'd0, 5'd0, 5'd4, 1'b0);
        #1;
        check("lw_r0_no_stall", 32'(outPCWrite), 32'd1);

        // Hazard and flush in the same cycle: flush wins, single bubble
        clear();
        set_in(6'd35, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
        step();
        set_in(6'd0, 6'h20, 5'd8, 5'd0, 5'd10, 1'b1);
        #1;
        check("fl_ifidflush", 32'(outIFIDFlush), 32'd1);
        check("fl_pcwrite", 32'(outPCWrite), 32'd1);
        check("fl_ifidwrite", 32'(outIFIDWrite), 32'd1);
        step();
        check("fl_bubble", 32'(sample()), 32'd0);
        set_in(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("fl_after_pcwrite", 32'(outPCWrite), 32'd1);

`ifdef PIPE_CTRL_MULDIV_EN
        // DIV then MFLO with MULDIV_CYCLES=4: busy 4 cycles, MFLO held then issued
        clear();
        set_in(6'd0, 6'h1A, 5'd1, 5'd2, 5'd0, 1'b0);
        #1;
        check("md_idle_busy", 32'(outBusy), 32'd0);
        step();
        set_in(6'd0, 6'h12, 5'd0, 5'd0, 5'd5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("md_busy_%0d", k), 32'(outBusy), 32'd1);
            check($sformatf("md_hold_%0d", k), 32'(outPCWrite), 32'd0);
            step();
        end
        check("md_busy_done", 32'(outBusy), 32'd0);
        check("md_release", 32'(outPCWrite), 32'd1);
        check("md_bubble_dest", 32'(exDestReg), 32'd0);
        step();
        check("md_mflo_fn", 32'(exFunction), 32'h12);
        check("md_mflo_dest", 32'(exDestReg), 32'd5);
`else
        // Without the tracker DIV is an ordinary R-type
        clear();
        set_in(6'd0, 6'h1A, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        check("div_plain_busy", 32'(outBusy), 32'd0);
        check("div_plain_fn", 32'(exFunction), 32'h1A);
        check("div_plain_dest", 32'(exDestReg), 32'd3);
        set_in(6'd0, 6'h12, 5'd0, 5'd0, 5'd5, 1'b0);
        #1;
        check("mflo_no_hold", 32'(outPCWrite), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
